// File: rtl/needle_move_sequencer.sv
// Board-RAM sequencer: loads the start position and applies moves to a 64x4 board RAM.
// Each move is read, validated, written back, and then announced to the needle core.
module needle_move_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_start,
  input  logic       mv_valid,
  output logic       mv_ready,
  input  logic [5:0] mv_from,
  input  logic [5:0] mv_to,
  output logic [5:0] board_addr,
  output logic       board_we,
  output logic [3:0] board_wdata,
  input  logic [3:0] board_rdata,
  output logic       step,
  output logic       player_move,
  output logic [5:0] player_from,
  output logic [5:0] player_to,
  output logic       captured,
  output logic [3:0] captured_piece,
  output logic       err,
  output logic       busy,
  output logic [7:0] move_count
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RD_FROM,
    RD_TO,
    CHK,
    WR_FROM,
    WR_TO,
    STEP
  } state_t;

  state_t     state_q;
  logic [5:0] cnt_q;
  logic [5:0] cnt_d;
  logic [5:0] from_q;
  logic [5:0] to_q;
  logic [3:0] piece_q;
  logic [3:0] tgt_q;
  logic [5:0] addr_q;
  logic       we_q;
  logic [3:0] wdata_q;
  logic       step_q;
  logic       pmove_q;
  logic [5:0] pfrom_q;
  logic [5:0] pto_q;
  logic       cap_q;
  logic [3:0] cpiece_q;
  logic       err_q;
  logic [7:0] count_q;
  logic [7:0] count_d;

  // Back ranks differ only in the corner squares.
  function automatic logic [3:0] back_rank(
    input logic [2:0] f,
    input logic [3:0] corner
  );
    logic [3:0] p;
    unique case (f)
      3'd0, 3'd7: p = corner;
      3'd1, 3'd6: p = 4'h4;
      3'd2, 3'd5: p = 4'h6;
      3'd3:       p = 4'hA;
      default:    p = 4'hC;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] start_piece(
    input logic [5:0] sq
  );
    logic [3:0] p;
    unique case (sq[5:3])
      3'd0:    p = back_rank(sq[2:0], 4'h8);
      3'd1:    p = 4'h1;
      3'd6:    p = 4'h9;
      3'd7:    p = back_rank(sq[2:0], 4'hC);
      default: p = 4'h0;
    endcase
    return p;
  endfunction

  assign cnt_d   = cnt_q + 6'd1;
  assign count_d = count_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      from_q   <= '0;
      to_q     <= '0;
      piece_q  <= '0;
      tgt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      step_q   <= 1'b0;
      pmove_q  <= 1'b0;
      pfrom_q  <= '0;
      pto_q    <= '0;
      cap_q    <= 1'b0;
      cpiece_q <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      step_q  <= 1'b0;
      pmove_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (init_start) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b1;
            wdata_q  <= start_piece(6'd0);
            count_q  <= '0;
            cap_q    <= 1'b0;
            cpiece_q <= '0;
            pfrom_q  <= '0;
            pto_q    <= '0;
          end else if (mv_valid) begin
            state_q <= RD_FROM;
            from_q  <= mv_from;
            to_q    <= mv_to;
            addr_q  <= mv_from;
            we_q    <= 1'b0;
          end
        end
        INIT: begin
          if (cnt_q == 6'd63) begin
            state_q <= STEP;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            step_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
            addr_q  <= cnt_d;
            wdata_q <= start_piece(cnt_d);
          end
        end
        RD_FROM: begin
          state_q <= RD_TO;
          addr_q  <= to_q;
        end
        RD_TO: begin
          // Rejection is decided here so err is visible while in CHK.
          state_q <= CHK;
          piece_q <= board_rdata;
          err_q   <= (board_rdata == 4'h0) || (from_q == to_q);
        end
        CHK: begin
          tgt_q <= board_rdata;
          if (err_q) begin
            state_q <= IDLE;
            addr_q  <= '0;
          end else begin
            state_q <= WR_FROM;
            we_q    <= 1'b1;
            addr_q  <= from_q;
            wdata_q <= 4'h0;
          end
        end
        WR_FROM: begin
          state_q  <= WR_TO;
          we_q     <= 1'b1;
          addr_q   <= to_q;
          wdata_q  <= piece_q;
          cap_q    <= (tgt_q != 4'h0);
          cpiece_q <= tgt_q;
        end
        WR_TO: begin
          state_q <= STEP;
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          step_q  <= 1'b1;
          pmove_q <= 1'b1;
          pfrom_q <= from_q;
          pto_q   <= to_q;
          count_q <= count_d;
        end
        STEP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mv_ready       = (state_q == IDLE) & ~init_start;
  assign busy           = (state_q != IDLE);
  assign board_addr     = addr_q;
  assign board_we       = we_q;
  assign board_wdata    = wdata_q;
  assign step           = step_q;
  assign player_move    = pmove_q;
  assign player_from    = pfrom_q;
  assign player_to      = pto_q;
  assign captured       = cap_q;
  assign captured_piece = cpiece_q;
  assign err            = err_q;
  assign move_count     = count_q;

endmodule

// File: doc/needle_move_sequencer.md
NEEDLE_MOVE_SEQUENCER -- requirements
Module: needle_move_sequencer

Interface
REQ-001 clk  in  1  sole clock, all state on rising edge.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 init_start  in  1  pulse: load standard start position into board RAM.
REQ-004 mv_valid  in  1  move request valid.
REQ-005 mv_ready  out  1  move request accepted when mv_valid&mv_ready.
REQ-006 mv_from  in  6  source square, 0=a1 .. 63=h8, sampled on accept.
REQ-007 mv_to  in  6  destination square, sampled on accept.
REQ-008 board_addr  out  6  board RAM address (64x4).
REQ-009 board_we  out  1  board RAM write enable.
REQ-010 board_wdata  out  4  piece code to write; 0 = empty.
REQ-011 board_rdata  in  4  RAM read data, valid one cycle after board_addr.
REQ-012 step  out  1  one-cycle pulse to needle core: board updated.
REQ-013 player_move  out  1  high with step when step follows a move (low after init).
REQ-014 player_from  out  6  last applied source; player_to  out  6  last applied destination.
REQ-015 captured  out  1  last move overwrote a non-empty square; captured_piece  out  4  its code.
REQ-016 err  out  1  one-cycle pulse: move rejected.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 move_count  out  8  applied moves since reset/init.

Function
REQ-019 States: IDLE, INIT, RD_FROM, RD_TO, CHK, WR_FROM, WR_TO, STEP.
REQ-020 mv_ready = (state==IDLE) & ~init_start; init_start wins a same-cycle conflict.
REQ-021 IDLE & init_start -> INIT; init_start outside IDLE ignored.
REQ-022 INIT: 64 cycles, counter 0..63, board_we=1, board_addr=counter, board_wdata per REQ-023; after square 63 -> STEP.
REQ-023 Start table: sq0-7 = 8,4,6,A,C,6,4,8; sq8-15 = 1; sq16-47 = 0; sq48-55 = 9; sq56-63 = C,4,6,A,C,6,4,C (hex).
REQ-024 INIT clears move_count, captured, captured_piece, player_from, player_to to 0.
REQ-025 Accept in IDLE -> RD_FROM: board_addr=from, board_we=0.
REQ-026 RD_TO: board_addr=to; latch board_rdata as moving piece.
REQ-027 CHK: latch board_rdata as target piece; if moving piece==0 or from==to: pulse err, no writes, no step, -> IDLE.
REQ-028 WR_FROM: board_we=1, addr=from, wdata=0.
REQ-029 WR_TO: board_we=1, addr=to, wdata=moving piece; captured=(target!=0), captured_piece=target.
REQ-030 STEP: step=1 one cycle; after move: player_move=1, player_from/player_to updated, move_count+1 (wraps 255->0); after INIT: player_move=0, count unchanged from 0; -> IDLE.
REQ-031 Latency: accept at cycle T -> writes T+4,T+5, step at T+6, mv_ready again T+7. Init: init_start at T -> writes T+1..T+64, step T+65.
REQ-032 No piece-legality or colour checks; captures by overwrite only.
REQ-033 board_we low in every state not listed in REQ-022/028/029; board_addr 0 in IDLE.

Reset
REQ-034 rst in any state -> IDLE next edge; all outputs 0 (mv_ready 1 after reset deasserts), move_count 0; in-flight move/init aborted, no further writes, board contents left as-is.
REQ-035 rst overrides init_start and mv_valid in the same cycle.

Verification
REQ-036 init_start pulse -> 64 writes matching REQ-023 (sq4=C, sq12=1, sq52=9, sq63=C), step at T+65 with player_move=0, move_count=0.
REQ-037 After init, move 12->28 -> write 28<-1 preceded by 12<-0, step at T+6, player_move=1, captured=0, move_count=1.
REQ-038 Sequence 12->28, 52->36, 11->27, 36->27 -> fourth move captured=1, captured_piece=1, sq27=9, move_count=4.
REQ-039 Move from empty sq 20 and move 5->5 -> err pulse at T+3 each, no board_we, no step, move_count unchanged.
REQ-040 init_start and mv_valid same IDLE cycle -> init runs, move not accepted; rst asserted mid-INIT at square 30 -> no writes after, busy=0, move_count=0 next cycle.
REQ-041 255 applied moves then one more -> move_count wraps to 0.
